// File: rtl/gu_pkg.sv
// Shared definitions for the sprite graphing-unit draw path: scheduler state
// encoding, screen bounds and the coordinate/colour widths that every
// graphing unit and the VGA adapter agree on.
package gu_pkg;

    // Number of graphing units sharing the VGA write port.
    localparam int GU_N = 4;

    // Pixel bus widths shared by the graphing units and the VGA adapter.
    localparam int GU_X_W = 9;
    localparam int GU_Y_W = 8;
    localparam int GU_C_W = 3;

    // First off-screen coordinate on each axis (exclusive bounds).
    localparam int GU_X_MAX = 320;
    localparam int GU_Y_MAX = 240;

    // Hung-unit watchdog: maximum WAIT cycles and the counter width.
    localparam int GU_TIMEOUT = 8191;
    localparam int GU_CNT_W   = 16;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } gu_state_e;

    // Index width for addressing n requesters (at least one bit).
    function automatic int gu_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gu_rr_pick.sv
// Combinational round-robin priority picker: returns the first asserted
// request at or above ptr_i, wrapping modulo N.
module gu_rr_pick
    import gu_pkg::*;
#(
    parameter int N     = GU_N,
    parameter int IDX_W = gu_idx_w(GU_N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Search every rotation with constant indices; the highest offset is
    // visited first so the lowest offset from ptr_i wins.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise paths that skip an assignment infer
    // a latch.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int p = 0; p < N; p++) begin
            if (ptr_i == IDX_W'(p)) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_i[(p + k) % N]) begin
                        valid_o = 1'b1;
                        idx_o   = IDX_W'((p + k) % N);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/gu_draw_scheduler.sv
// Shares the single VGA adapter write port between N sprite graphing units.
// A round-robin arbiter grants one unit at a time, pulses its plot input,
// forwards its pixel stream (registered, clipped to the screen) until the
// unit reports done, then acknowledges the requester. A watchdog aborts a
// draw whose unit never reports done and raises a sticky error flag.
module gu_draw_scheduler
    import gu_pkg::*;
#(
    parameter int N       = GU_N,
    parameter int X_W     = GU_X_W,
    parameter int Y_W     = GU_Y_W,
    parameter int C_W     = GU_C_W,
    parameter int X_MAX   = GU_X_MAX,
    parameter int Y_MAX   = GU_Y_MAX,
    parameter int TIMEOUT = GU_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     gu_plot,
    input  logic [N*X_W-1:0] gu_x_in,
    input  logic [N*Y_W-1:0] gu_y_in,
    input  logic [N*C_W-1:0] gu_colour_in,
    input  logic [N-1:0]     gu_we_in,
    input  logic [N-1:0]     gu_done_in,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [C_W-1:0]   vga_colour,
    output logic             vga_writeEn,
    output logic             busy,
    output logic             timeout_err
);

    localparam int IDX_W = gu_idx_w(N);

    // Bounds and watchdog limit sized to the buses they are compared with,
    // so every comparison is unsigned at full coordinate width.
    localparam logic [X_W-1:0]      X_LIM   = X_W'(X_MAX);
    localparam logic [Y_W-1:0]      Y_LIM   = Y_W'(Y_MAX);
    localparam logic [GU_CNT_W-1:0] CNT_LIM = GU_CNT_W'(TIMEOUT);

    // Arbitration and transaction state.
    gu_state_e             state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [GU_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  terr_q, terr_d;

    // Registered VGA port.
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [C_W-1:0]        vga_c_q, vga_c_d;
    logic                  vga_we_q, vga_we_d;

    // Picker result and the selected unit's stream.
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      ptr_after;
    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic [C_W-1:0]        sel_c;
    logic                  sel_we;
    logic                  sel_done;

    gu_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // The unit after the current one gets first priority next time.
    assign ptr_after = (sel_q == IDX_W'(N - 1)) ? '0 : sel_q + 1'b1;

    assign sel_we   = gu_we_in[sel_q];
    assign sel_done = gu_done_in[sel_q];

    // Multiplex the selected unit's packed pixel slice.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_x = gu_x_in[i*X_W +: X_W];
                sel_y = gu_y_in[i*Y_W +: Y_W];
                sel_c = gu_colour_in[i*C_W +: C_W];
            end
        end
    end

    // Next-state, watchdog and one-cycle plot/ack pulse decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        gu_plot = '0;
        ack     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // done from the unit is not looked at here: it may still be
                // reporting the end of its previous sprite.
                gu_plot[sel_q] = 1'b1;
                cnt_d          = '0;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_done) begin
                    state_d = ST_FINISH;
                end else if (cnt_q == CNT_LIM) begin
                    terr_d  = 1'b1;
                    ptr_d   = ptr_after;
                    state_d = ST_IDLE;
                end
            end
            ST_FINISH: begin
                ack[sel_q] = 1'b1;
                ptr_d      = ptr_after;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Forwarded pixel: coordinates always follow the selected unit, the
    // write strobe only while drawing and only for on-screen pixels.
    always_comb begin
        vga_x_d  = sel_x;
        vga_y_d  = sel_y;
        vga_c_d  = sel_c;
        vga_we_d = (state_q == ST_WAIT) && sel_we &&
                   (sel_x < X_LIM) && (sel_y < Y_LIM);
    end

    // State and output registers; reset aborts any transaction at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            vga_x_q  <= '0;
            vga_y_q  <= '0;
            vga_c_q  <= '0;
            vga_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            vga_c_q  <= vga_c_d;
            vga_we_q <= vga_we_d;
        end
    end

    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_c_q;
    assign vga_writeEn = vga_we_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_gu_draw_scheduler.sv
// Directed bench for gu_draw_scheduler (built with a 16-cycle watchdog).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gu_draw_scheduler;

    localparam int N       = 4;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int C_W     = 3;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             resetn;
    logic             enable;
    logic [N-1:0]     req;
    logic [N-1:0]     ack;
    logic [N-1:0]     gu_plot;
    logic [N*X_W-1:0] gu_x_in;
    logic [N*Y_W-1:0] gu_y_in;
    logic [N*C_W-1:0] gu_colour_in;
    logic [N-1:0]     gu_we_in;
    logic [N-1:0]     gu_done_in;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [C_W-1:0]   vga_colour;
    logic             vga_writeEn;
    logic             busy;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    gu_draw_scheduler #(
        .N       (N),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .C_W     (C_W),
        .X_MAX   (320),
        .Y_MAX   (240),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .req          (req),
        .ack          (ack),
        .gu_plot      (gu_plot),
        .gu_x_in      (gu_x_in),
        .gu_y_in      (gu_y_in),
        .gu_colour_in (gu_colour_in),
        .gu_we_in     (gu_we_in),
        .gu_done_in   (gu_done_in),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_writeEn  (vga_writeEn),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_unit(input int i, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                            input logic [C_W-1:0] c, input logic we, input logic done);
        gu_x_in[i*X_W +: X_W]      = x;
        gu_y_in[i*Y_W +: Y_W]      = y;
        gu_colour_in[i*C_W +: C_W] = c;
        gu_we_in[i]                = we;
        gu_done_in[i]              = done;
    endtask

    // Advance until a plot pulse appears or the budget runs out.
    task automatic wait_plot(input int budget, output logic [N-1:0] p, output int cyc);
        p   = '0;
        cyc = 0;
        while (cyc < budget && p == '0) begin
            tick();
            cyc++;
            p = gu_plot;
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        logic [N-1:0] p;
        logic [N-1:0] prev_ack;
        int cyc;
        int grants;
        int cur;
        int tc;
        int nplot;
        logic saw_ack;
        int dly[N];
        int rearm[N];
        int exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        resetn = 1'b0;
        enable = 1'b0;
        req = '0;
        gu_x_in = '0;
        gu_y_in = '0;
        gu_colour_in = '0;
        gu_we_in = '0;
        gu_done_in = '0;
        repeat (3) tick();

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_plot", gu_plot, 0);
        check("rst_we", vga_writeEn, 0);
        check("rst_x", vga_x, 0);
        check("rst_terr", timeout_err, 0);
        resetn = 1'b1;

        // Single requester: plot one cycle after req, pixel one cycle later.
        tick();
        enable = 1'b1;
        req = 4'b0001;
        wait_plot(4, p, cyc);
        check("single_plot", p, 4'b0001);
        check("single_plot_lat", cyc, 1);
        check("single_busy", busy, 1);
        set_unit(0, 9'd10, 8'd10, 3'd5, 1'b1, 1'b0);
        tick();
        check("single_plot_1cyc", gu_plot, 0);
        check("single_we_start", vga_writeEn, 0);
        tick();
        check("single_x", vga_x, 10);
        check("single_y", vga_y, 10);
        check("single_col", vga_colour, 5);
        check("single_we", vga_writeEn, 1);
        set_unit(0, 9'd10, 8'd10, 3'd5, 1'b0, 1'b1);
        tick();
        check("single_ack", ack, 4'b0001);
        set_unit(0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        req = '0;
        tick();
        check("single_ack_1cyc", ack, 0);
        check("single_idle", busy, 0);

        // Clipping on unit 1; unit 0 drives we/done that must be ignored.
        req = 4'b0010;
        set_unit(0, 9'd5, 8'd5, 3'd1, 1'b1, 1'b1);
        wait_plot(4, p, cyc);
        check("clip_plot", p, 4'b0010);
        set_unit(1, 9'd319, 8'd239, 3'd2, 1'b1, 1'b1);
        tick();
        check("done_in_start", ack, 0);
        set_unit(1, 9'd319, 8'd239, 3'd2, 1'b1, 1'b0);
        tick();
        check("clip_in_we", vga_writeEn, 1);
        check("clip_in_x", vga_x, 319);
        set_unit(1, 9'd320, 8'd10, 3'd2, 1'b1, 1'b0);
        tick();
        check("clip_x_we", vga_writeEn, 0);
        check("clip_x_x", vga_x, 320);
        set_unit(1, 9'd10, 8'd240, 3'd2, 1'b1, 1'b0);
        tick();
        check("clip_y_we", vga_writeEn, 0);
        check("clip_y_y", vga_y, 240);
        check("other_done", ack, 0);
        set_unit(0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        set_unit(1, 9'd0, 8'd0, 3'd0, 1'b0, 1'b1);
        tick();
        check("clip_ack", ack, 4'b0010);
        set_unit(1, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        req = '0;
        tick();

        // Round robin from a fresh pointer; each unit reports done 12 cycles
        // after its plot (inside the 16-cycle watchdog).
        do_reset();
        enable = 1'b1;
        req = 4'b1111;
        grants = 0;
        cur = -1;
        cyc = 0;
        prev_ack = '0;
        for (int i = 0; i < N; i++) begin
            dly[i] = -1;
            rearm[i] = -1;
        end
        while (grants < 5 && cyc < 400) begin
            tick();
            cyc++;
            for (int i = 0; i < N; i++) begin
                gu_done_in[i] = 1'b0;
                if (dly[i] > 0) begin
                    dly[i]--;
                    if (dly[i] == 0) begin
                        gu_done_in[i] = 1'b1;
                        dly[i] = -1;
                    end
                end
                if (rearm[i] > 0) begin
                    rearm[i]--;
                    if (rearm[i] == 0) begin
                        req[i] = 1'b1;
                        rearm[i] = -1;
                    end
                end
            end
            if (gu_plot != '0) begin
                check("rr_plot_onehot", 32'($onehot(gu_plot)), 1);
                cur = onehot_idx(gu_plot);
                check("rr_order", cur, exp_order[grants]);
                grants++;
                dly[cur] = 12;
            end
            if (ack != '0) begin
                check("rr_ack_idx", ack, 32'(1) << cur);
                check("rr_ack_1cyc", prev_ack, 0);
                req[cur] = 1'b0;
                rearm[cur] = 2;
            end
            prev_ack = ack;
        end
        check("rr_grants", grants, 5);

        // done in the very cycle the counter reaches TIMEOUT wins.
        gu_done_in = '0;
        req = '0;
        do_reset();
        req = 4'b0001;
        wait_plot(4, p, cyc);
        check("prio_plot", p, 4'b0001);
        repeat (TIMEOUT + 1) tick();
        check("prio_pre_ack", ack, 0);
        gu_done_in[0] = 1'b1;
        tick();
        check("prio_ack", ack, 4'b0001);
        check("prio_terr", timeout_err, 0);
        gu_done_in[0] = 1'b0;
        req = '0;
        tick();

        // Timeout: unit 2 never reports done. WAIT cycles see counter 0..16,
        // the abort happens at the end of the 17th, flag visible one later.
        req = 4'b0100;
        wait_plot(4, p, cyc);
        check("to_plot", p, 4'b0100);
        tc = 0;
        saw_ack = 1'b0;
        while (!timeout_err && tc < 40) begin
            tick();
            tc++;
            if (ack != '0) saw_ack = 1'b1;
        end
        check("to_cycles", tc, TIMEOUT + 2);
        check("to_flag", timeout_err, 1);
        check("to_no_ack", saw_ack, 0);
        check("to_idle", busy, 0);
        req = 4'b1100;
        wait_plot(4, p, cyc);
        check("to_next_grant", p, 4'b1000);
        tick();
        gu_done_in[3] = 1'b1;
        req = '0;
        tick();
        check("to_next_ack", ack, 4'b1000);
        check("to_sticky", timeout_err, 1);
        gu_done_in[3] = 1'b0;
        tick();

        // Enable gating.
        enable = 1'b0;
        req = 4'b0010;
        nplot = 0;
        repeat (50) begin
            tick();
            if (gu_plot != '0) nplot++;
        end
        check("en_low_plots", nplot, 0);
        check("en_low_busy", busy, 0);
        enable = 1'b1;
        wait_plot(4, p, cyc);
        check("en_plot", p, 4'b0010);
        tick();
        enable = 1'b0;
        req = '0;
        repeat (5) tick();
        gu_done_in[1] = 1'b1;
        tick();
        check("en_drop_ack", ack, 4'b0010);
        gu_done_in[1] = 1'b0;
        tick();
        req = 4'b0010;
        nplot = 0;
        repeat (10) begin
            tick();
            if (gu_plot != '0) nplot++;
        end
        check("en_after_plots", nplot, 0);

        // Asynchronous reset during WAIT.
        enable = 1'b1;
        req = 4'b1000;
        wait_plot(4, p, cyc);
        check("mid_plot", p, 4'b1000);
        set_unit(3, 9'd100, 8'd50, 3'd6, 1'b1, 1'b0);
        tick();
        tick();
        check("mid_we", vga_writeEn, 1);
        check("mid_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_we", vga_writeEn, 0);
        check("arst_x", vga_x, 0);
        check("arst_col", vga_colour, 0);
        check("arst_terr", timeout_err, 0);
        check("arst_plot_ack", {gu_plot, ack}, 0);
        tick();
        resetn = 1'b1;
        set_unit(3, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        req = 4'b0110;
        wait_plot(4, p, cyc);
        check("post_rst_ptr", p, 4'b0010);
        tick();
        gu_done_in[1] = 1'b1;
        req = 4'b0100;
        tick();
        check("post_rst_ack", ack, 4'b0010);
        gu_done_in[1] = 1'b0;
        wait_plot(4, p, cyc);
        check("post_rst_u2", p, 4'b0100);
        tick();
        gu_done_in[2] = 1'b1;
        req = '0;
        tick();
        check("post_rst_ack2", ack, 4'b0100);
        gu_done_in[2] = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
